// File: rtl/riscv_lsu.sv
// Load/store unit: registers a core access, issues one word-aligned byte-enabled memory request, returns extended load data.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_CHECK_EN.
module riscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] rd_q, rd_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic        misalign_q, misalign_d;
    logic        misalign_req;

    function automatic logic is_byte(input logic [2:0] size);
        return (size == 3'd0) || (size == 3'd4);
    endfunction

    function automatic logic is_half(input logic [2:0] size);
        return (size == 3'd1) || (size == 3'd5);
    endfunction

    // Sizes 3, 6 and 7 fall through to a full-word access.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] be;
        if (is_byte(size)) begin
            be = 4'b0001 << lo;
        end else if (is_half(size)) begin
            be = lo[1] ? 4'b1100 : 4'b0011;
        end else begin
            be = 4'b1111;
        end
        return be;
    endfunction

    function automatic logic [31:0] lane_wd(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] res;
        if (is_byte(size)) begin
            res = {4{wd[7:0]}};
        end else if (is_half(size)) begin
            res = {2{wd[15:0]}};
        end else begin
            res = wd;
        end
        return res;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  size,
                                                input logic [1:0]  lo,
                                                input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            3'd0:    res = 32'(b);
            3'd1:    res = 32'(h);
            3'd4:    res = {24'd0, b};
            3'd5:    res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
        logic res;
        if (is_byte(size)) begin
            res = 1'b0;
        end else if (is_half(size)) begin
            res = lo[0];
        end else begin
            res = (lo != 2'd0);
        end
        return res;
    endfunction

    assign misalign_req = misaligned(core_size_i, core_addr_i[1:0]);
`else
    assign misalign_req = 1'b0;
`endif

    assign core_stall_o = core_req_i && (state_q != DONE);

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        lo_d       = lo_q;
        rd_d       = rd_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    we_d   = core_we_i;
                    size_d = core_size_i;
                    lo_d   = core_addr_i[1:0];
                    if (misalign_req) begin
                        misalign_d = 1'b1;
                        rd_d       = 32'd0;
                        state_d    = DONE;
                    end else begin
                        mem_req_d = 1'b1;
                        mem_we_d  = core_we_i;
                        be_d      = byte_en(core_size_i, core_addr_i[1:0]);
                        addr_d    = {core_addr_i[31:2], 2'b00};
                        wd_d      = lane_wd(core_size_i, core_wd_i);
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                // Request stays up until the memory acknowledges, even if the core drops its request.
                if (mem_ready_i) begin
                    rd_d      = we_q ? 32'd0 : load_extend(size_q, lo_q, mem_rd_i);
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            rd_q       <= 32'd0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            be_q       <= 4'd0;
            addr_q     <= 32'd0;
            wd_q       <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            misalign_q <= misalign_d;
        end
    end

    // Access attributes are only consumed while BUSY, so they need no reset.
    always_ff @(posedge clk_i) begin
        we_q   <= we_d;
        size_q <= size_d;
        lo_q   <= lo_d;
    end

    assign core_rd_o  = rd_q;
    assign misalign_o = misalign_q;
    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_be_o   = be_q;
    assign mem_addr_o = addr_q;
    assign mem_wd_o   = wd_q;

endmodule
